// File: rtl/ring_shift_counter.sv
// ring_shift_counter: rotate/shift/count/Johnson register with free-run and fixed-length burst stepping
module ring_shift_counter #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = 1,
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       mode_i,
  input  logic             serial_in_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] steps_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic wrap_q, wrap_d, step_wrap;
  // one step of the selected operation and whether that step wraps
  always_comb begin
    step_val = mode_i == 3'd1 ? {count_q[WIDTH-2:0], count_q[WIDTH-1]} :
               mode_i == 3'd2 ? {count_q[0], count_q[WIDTH-1:1]} :
               mode_i == 3'd3 ? {count_q[WIDTH-2:0], serial_in_i} :
               mode_i == 3'd4 ? {serial_in_i, count_q[WIDTH-1:1]} :
               mode_i == 3'd5 ? count_q + WIDTH'(1) :
               mode_i == 3'd6 ? count_q - WIDTH'(1) :
               mode_i == 3'd7 ? {count_q[WIDTH-2:0], ~count_q[WIDTH-1]} : count_q;
    step_wrap = (mode_i == 3'd1 || mode_i == 3'd2 || mode_i == 3'd7) ? step_val == RESET_VALUE :
                mode_i == 3'd5 ? &count_q :
                mode_i == 3'd6 ? ~|count_q : 1'b0;
  end
  // next state: load overrides everything and aborts a burst without a done pulse
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = data_i;
      state_d = IDLE;
    end else if (state_q == IDLE && start_i) begin
      rem_d   = steps_i;
      state_d = steps_i == '0 ? DONE : RUN;
    end else if (state_q == RUN || (state_q == IDLE && enable_i)) begin
      count_d = step_val;
      wrap_d  = step_wrap;
      if (state_q == RUN) begin
        rem_d   = rem_q - CNT_W'(1);
        state_d = rem_q == CNT_W'(1) ? DONE : RUN;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= RESET_VALUE;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign busy_o  = state_q == RUN;
  assign done_o  = state_q == DONE;
endmodule

// File: tb/tb_ring_shift_counter.sv
// tb_ring_shift_counter: table-driven and sequence checks for ring_shift_counter
module tb_ring_shift_counter;
  logic clock = 0, reset, load, serial_in, enable, start, busy, done, wrap;
  logic [3:0] data, count;
  logic [2:0] mode;
  logic [7:0] steps;
  int tests = 0, fails = 0;
  always #5 clock = ~clock;
  ring_shift_counter dut (
    .clock_i(clock), .reset_i(reset), .load_i(load), .data_i(data), .mode_i(mode),
    .serial_in_i(serial_in), .enable_i(enable), .start_i(start), .steps_i(steps),
    .count_o(count), .busy_o(busy), .done_o(done), .wrap_o(wrap)
  );
  typedef struct {
    logic ld; logic [3:0] d; logic [2:0] m; logic s, en, st; logic [7:0] n;
    logic [3:0] c; logic b, dn, w;
  } vec_t;
  vec_t v[$];
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(logic ld, logic [3:0] d, logic [2:0] m, logic s, logic en, logic st, logic [7:0] n);
    load = ld; data = d; mode = m; serial_in = s; enable = en; start = st; steps = n;
  endtask
  task automatic outs(string nm, logic [3:0] c, logic b, logic dn, logic w);
    chk({nm, " count"}, 32'(count), 32'(c));
    chk({nm, " busy"}, 32'(busy), 32'(b));
    chk({nm, " done"}, 32'(done), 32'(dn));
    chk({nm, " wrap"}, 32'(wrap), 32'(w));
  endtask
  task automatic add(logic ld, logic [3:0] d, logic [2:0] m, logic s, logic en, logic st, logic [7:0] n,
                     logic [3:0] c, logic b, logic dn, logic w);
    v.push_back('{ld, d, m, s, en, st, n, c, b, dn, w});
  endtask
  initial begin
    int dn_cnt, b_cnt;
    //  ld  data   mode  s  en st steps  count  b  d  w
    add(0, 4'h0, 3'd1, 0, 1, 0, 8'd0, 4'b0010, 0, 0, 0);
    add(0, 4'h0, 3'd1, 0, 1, 0, 8'd0, 4'b0100, 0, 0, 0);
    add(0, 4'h0, 3'd1, 0, 1, 0, 8'd0, 4'b1000, 0, 0, 0);
    add(0, 4'h0, 3'd1, 0, 1, 0, 8'd0, 4'b0001, 0, 0, 1);
    add(1, 4'hA, 3'd0, 0, 0, 0, 8'd0, 4'b1010, 0, 0, 0);
    add(0, 4'h0, 3'd2, 0, 0, 1, 8'd3, 4'b1010, 1, 0, 0);
    add(0, 4'h0, 3'd2, 0, 0, 0, 8'd0, 4'b0101, 1, 0, 0);
    add(0, 4'h0, 3'd2, 0, 0, 0, 8'd0, 4'b1010, 1, 0, 0);
    add(0, 4'h0, 3'd2, 0, 0, 0, 8'd0, 4'b0101, 0, 1, 0);
    add(0, 4'h0, 3'd2, 0, 0, 0, 8'd0, 4'b0101, 0, 0, 0);
    add(1, 4'hF, 3'd0, 0, 0, 0, 8'd0, 4'b1111, 0, 0, 0);
    add(0, 4'h0, 3'd5, 0, 1, 0, 8'd0, 4'b0000, 0, 0, 1);
    add(0, 4'h0, 3'd6, 0, 1, 0, 8'd0, 4'b1111, 0, 0, 1);
    add(1, 4'h3, 3'd0, 0, 0, 0, 8'd0, 4'b0011, 0, 0, 0);
    add(0, 4'h0, 3'd5, 0, 1, 0, 8'd0, 4'b0100, 0, 0, 0);
    add(1, 4'h0, 3'd0, 0, 0, 0, 8'd0, 4'b0000, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b0001, 0, 0, 1);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b0011, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b0111, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b1111, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b1110, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b1100, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b1000, 0, 0, 0);
    add(0, 4'h0, 3'd7, 0, 1, 0, 8'd0, 4'b0000, 0, 0, 0);
    add(0, 4'h0, 3'd3, 1, 1, 0, 8'd0, 4'b0001, 0, 0, 0);
    add(0, 4'h0, 3'd4, 1, 1, 0, 8'd0, 4'b1000, 0, 0, 0);
    add(0, 4'h0, 3'd0, 0, 1, 0, 8'd0, 4'b1000, 0, 0, 0);
    add(1, 4'h5, 3'd1, 0, 1, 1, 8'd5, 4'b0101, 0, 0, 0);
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    reset = 0;
    tick;
    outs("reset", 4'b0001, 0, 0, 0);
    foreach (v[i]) begin
      drive(v[i].ld, v[i].d, v[i].m, v[i].s, v[i].en, v[i].st, v[i].n);
      tick;
      outs($sformatf("vec%0d", i), v[i].c, v[i].b, v[i].dn, v[i].w);
    end
    drive(0, 0, 3'd1, 0, 0, 1, 8'd10);
    tick;
    outs("abort start", 4'b0101, 1, 0, 0);
    start = 0;
    tick;
    outs("abort step1", 4'b1010, 1, 0, 0);
    tick;
    outs("abort step2", 4'b0101, 1, 0, 0);
    load = 1; data = 4'b0110;
    tick;
    outs("abort load", 4'b0110, 0, 0, 0);
    load = 0;
    dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      dn_cnt += int'(done);
    end
    chk("abort no done", 32'(dn_cnt), 0);
    chk("abort hold", 32'(count), 32'(4'b0110));
    drive(0, 0, 3'd0, 0, 0, 1, 8'd2);
    tick;
    chk("rs busy0", 32'(busy), 1);
    steps = 8'd5;
    tick;
    chk("rs busy1", 32'(busy), 1);
    tick;
    outs("rs done", 4'b0110, 0, 1, 0);
    tick;
    outs("rs idle", 4'b0110, 0, 0, 0);
    tick;
    chk("rs restart", 32'(busy), 1);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("rs run%0d", i), 32'(busy), 1);
    end
    tick;
    chk("rs done2", 32'(done), 1);
    tick;
    drive(0, 0, 3'd1, 0, 0, 1, 8'd0);
    dn_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      start = 0;
      dn_cnt += int'(done);
      b_cnt += int'(busy);
    end
    chk("zero done", 32'(dn_cnt), 1);
    chk("zero busy", 32'(b_cnt), 0);
    chk("zero count", 32'(count), 32'(4'b0110));
    drive(0, 0, 3'd5, 0, 0, 1, 8'd5);
    tick;
    start = 0;
    tick;
    tick;
    outs("rst pre", 4'b1000, 1, 0, 0);
    reset = 1;
    tick;
    outs("rst mid", 4'b0001, 0, 0, 0);
    reset = 0;
    dn_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      dn_cnt += int'(done);
      b_cnt += int'(busy);
    end
    chk("rst no done", 32'(dn_cnt), 0);
    chk("rst no busy", 32'(b_cnt), 0);
    chk("rst count", 32'(count), 32'(4'b0001));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
